// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle LDM/STM block-transfer sequencer.
// Walks the register list lowest-to-highest, issuing one memory beat per
// register, and optionally writes the updated base back to the register file.
module ldm_stm_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  pre_index,
  input  logic                  up,
  input  logic                  base_wb,
  input  logic [3:0]            base_sel,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [3:0]            rf_read_sel,
  input  logic [31:0]           rf_read_data,
  output logic                  rf_write_enable,
  output logic [3:0]            rf_write_sel,
  output logic [31:0]           rf_write_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WB,
    S_DONE
  } state_t;

  state_t                state;
  logic [NUM_REGS-1:0]   pending;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] final_base_q;
  logic [3:0]            base_sel_q;
  logic                  load_q;
  logic                  wb_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_req_q;
  logic                  mem_we_q;

  logic [ADDR_WIDTH-1:0] n_bytes;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] final_base;
  logic                  wb_needed;
  logic [3:0]            cur_reg;
  logic                  last_beat;
  logic                  list_empty;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] lowest_set(input logic [NUM_REGS-1:0] v);
    logic [3:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (v[i] && !found) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Total bytes covered by the list: 4 per selected register.
  function automatic logic [ADDR_WIDTH-1:0] list_bytes(input logic [NUM_REGS-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (v[i]) cnt = cnt + 1;
    end
    return ADDR_WIDTH'(cnt * 4);
  endfunction

  // Launch-time address arithmetic from the live inputs (used only in IDLE).
  always_comb begin
    n_bytes    = list_bytes(reg_list);
    list_empty = (reg_list == '0);
    wb_needed  = base_wb && !(is_load && reg_list[base_sel]);
    final_base = up ? (base_addr + n_bytes) : (base_addr - n_bytes);
    unique case ({pre_index, up})
      2'b01:   start_addr = base_addr;
      2'b11:   start_addr = base_addr + ADDR_WIDTH'(4);
      2'b00:   start_addr = base_addr - n_bytes + ADDR_WIDTH'(4);
      default: start_addr = base_addr - n_bytes;
    endcase
  end

  // Current register and last-beat detection from the pending list.
  always_comb begin
    cur_reg   = lowest_set(pending);
    // v & (v-1) clears the lowest set bit; zero means only one bit remains.
    last_beat = ((pending & (pending - NUM_REGS'(1))) == '0);
  end

  // Sequencer state machine with registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pending      <= '0;
      cur_addr     <= '0;
      final_base_q <= '0;
      base_sel_q   <= '0;
      load_q       <= 1'b0;
      wb_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            load_q       <= is_load;
            wb_q         <= wb_needed;
            base_sel_q   <= base_sel;
            final_base_q <= final_base;
            if (list_empty) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state     <= S_XFER;
              pending   <= reg_list;
              cur_addr  <= start_addr;
              busy_q    <= 1'b1;
              mem_req_q <= 1'b1;
              mem_we_q  <= ~is_load;
            end
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            pending  <= pending & (pending - NUM_REGS'(1));
            cur_addr <= cur_addr + ADDR_WIDTH'(4);
            if (last_beat) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              if (wb_q) begin
                state <= S_WB;
              end else begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
        end
        S_WB: begin
          state  <= S_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Register-file write port: load data on an accepted beat, or base writeback.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_sel    = '0;
    rf_write_data   = '0;
    if ((state == S_XFER) && load_q && mem_ready) begin
      rf_write_enable = 1'b1;
      rf_write_sel    = cur_reg;
      rf_write_data   = mem_rdata;
    end else if (state == S_WB) begin
      rf_write_enable = 1'b1;
      rf_write_sel    = base_sel_q;
      rf_write_data   = 32'(final_base_q);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = cur_addr;
  assign rf_read_sel = cur_reg;
  assign mem_wdata   = (mem_req_q && mem_we_q) ? rf_read_data : '0;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a reference model predicts memory
// beats, register-file writes and done timing; a monitor checks the DUT.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        pre_index;
  logic        up;
  logic        base_wb;
  logic [3:0]  base_sel;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  rf_read_sel;
  logic [31:0] rf_read_data;
  logic        rf_write_enable;
  logic [3:0]  rf_write_sel;
  logic [31:0] rf_write_data;

  ldm_stm_sequencer #(.ADDR_WIDTH(32), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load),
    .pre_index(pre_index), .up(up), .base_wb(base_wb), .base_sel(base_sel),
    .base_addr(base_addr), .reg_list(reg_list), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rf_read_sel(rf_read_sel), .rf_read_data(rf_read_data),
    .rf_write_enable(rf_write_enable), .rf_write_sel(rf_write_sel),
    .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic [3:0] sel; logic [31:0] data; } rfw_t;
  typedef struct { int waits; logic [31:0] data; } resp_t;
  typedef struct { int cyc; int busy; } done_t;

  beat_t       beat_q[$];
  rfw_t        rfw_q[$];
  resp_t       resp_q[$];
  done_t       done_q[$];
  logic [31:0] fixed_rdata[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  bit have_beat = 0;
  int wait_left = 0;
  logic [31:0] beat_data;

  // Environment register file (written by DUT and by preload requests).
  logic [31:0] env_rf[16];
  logic        tb_wr_en = 1'b0;
  logic [3:0]  tb_wr_sel = '0;
  logic [31:0] tb_wr_data = '0;
  // Reference register contents tracked by the model.
  logic [31:0] ref_rf[16];

  assign rf_read_data = env_rf[rf_read_sel];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_write_enable) env_rf[rf_write_sel] <= rf_write_data;
    if (tb_wr_en) env_rf[tb_wr_sel] <= tb_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%08h required=none", name, act);
  endtask

  // Memory responder: per-beat wait states and load data come from resp_q.
  initial begin
    resp_t r;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!reset && mem_req) begin
        if (!have_beat) begin
          if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            wait_left = r.waits;
            beat_data = r.data;
          end else begin
            wait_left = 0;
            beat_data = $urandom;
          end
          have_beat = 1;
        end
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = beat_data;
          have_beat = 0;
        end
      end
    end
  end

  // Monitor: compares every presented beat, rf write and done pulse.
  initial begin
    beat_t b;
    rfw_t  w;
    done_t d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req) begin
          if (beat_q.size() == 0) begin
            flag("unexpected_beat", mem_addr);
          end else begin
            b = beat_q[0];
            check("beat_we", 32'(mem_we), 32'(b.we));
            check("beat_addr", mem_addr, b.addr);
            if (b.we) check("beat_wdata", mem_wdata, b.data);
            if (mem_ready) void'(beat_q.pop_front());
          end
        end
        if (rf_write_enable) begin
          if (rfw_q.size() == 0) begin
            flag("unexpected_rf_write", 32'(rf_write_sel));
          end else begin
            w = rfw_q.pop_front();
            check("rf_write_sel", 32'(rf_write_sel), 32'(w.sel));
            check("rf_write_data", rf_write_data, w.data);
          end
        end
        if (busy) busy_cnt++;
        if (done) begin
          if (done_q.size() == 0) begin
            flag("unexpected_done", 32'(cyc));
          end else begin
            d = done_q.pop_front();
            check("done_cycle", 32'(cyc), 32'(d.cyc));
            check("busy_cycles", 32'(busy_cnt), 32'(d.busy));
            check("busy_at_done", 32'(busy), 32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic set_reg(input int i, input logic [31:0] v);
    @(posedge clk); #1;
    tb_wr_en = 1'b1;
    tb_wr_sel = 4'(i);
    tb_wr_data = v;
    ref_rf[i] = v;
    @(posedge clk); #1;
    tb_wr_en = 1'b0;
  endtask

  // Reference model: predicts the whole transfer from the block-transfer rules.
  task automatic launch(input bit ld, input bit p, input bit u, input bit w,
                        input logic [3:0] bs, input logic [15:0] list, input int wmode);
    logic [31:0] base, lowest, fin, a, d;
    int n, tw, wbc, ws;
    @(posedge clk); #1;
    base = ref_rf[bs];
    n = $countones(list);
    lowest = u ? base + (p ? 32'd4 : 32'd0) : base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    fin = u ? base + 32'(4 * n) : base - 32'(4 * n);
    a = lowest;
    tw = 0;
    for (int r = 0; r < 16; r++) begin
      if (list[r]) begin
        ws = (wmode >= 0) ? wmode : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        d = (fixed_rdata.size() > 0) ? fixed_rdata.pop_front() : $urandom;
        resp_q.push_back('{ws, d});
        if (ld) begin
          beat_q.push_back('{1'b0, a, 32'd0});
          rfw_q.push_back('{4'(r), d});
          ref_rf[r] = d;
        end else begin
          beat_q.push_back('{1'b1, a, ref_rf[r]});
        end
        a = a + 32'd4;
        tw += ws;
      end
    end
    wbc = (n > 0 && w && !(ld && list[bs])) ? 1 : 0;
    if (wbc == 1) begin
      rfw_q.push_back('{bs, fin});
      ref_rf[bs] = fin;
    end
    if (n > 0) done_q.push_back('{cyc + 1 + n + tw + wbc, n + tw + wbc});
    else done_q.push_back('{cyc + 1, 0});
    start = 1'b1; is_load = ld; pre_index = p; up = u; base_wb = w;
    base_sel = bs; base_addr = base; reg_list = list;
  endtask

  task automatic drive_garbage();
    start = 1'b1; is_load = 1'($urandom); pre_index = 1'($urandom);
    up = 1'($urandom); base_wb = 1'($urandom); base_sel = 4'($urandom);
    base_addr = $urandom; reg_list = 16'($urandom) | 16'h0001;
  endtask

  // Waits for done; with hold=1, start stays high with junk while busy and in DONE.
  task automatic wait_done(input bit hold);
    bit seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (seen) begin
        start = 1'b0;
        break;
      end
      if (hold) drive_garbage(); else start = 1'b0;
      if (done) seen = 1;
    end
    if (!seen) begin
      start = 1'b0;
      flag("done_timeout", 32'(cyc));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] list;
    logic [3:0]  bs;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; pre_index = 1'b0; up = 1'b0;
    base_wb = 1'b0; base_sel = '0; base_addr = '0; reg_list = '0;
    for (int i = 0; i < 16; i++) begin
      env_rf[i] = '0;
      ref_rf[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_rf_we", 32'(rf_write_enable), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) set_reg(i, $urandom);

    // STMIA with writeback.
    set_reg(0, 32'h100); set_reg(1, 32'hA1); set_reg(2, 32'hA2); set_reg(5, 32'hA5);
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0026, 0);
    wait_done(1'b0);
    check("stmia_base_wb", env_rf[0], 32'h10C);

    // LDMDB with writeback.
    set_reg(6, 32'h200);
    fixed_rdata.push_back(32'h33); fixed_rdata.push_back(32'h44);
    launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 16'h0018, 0);
    wait_done(1'b0);
    check("ldmdb_r3", env_rf[3], 32'h33);
    check("ldmdb_r4", env_rf[4], 32'h44);
    check("ldmdb_base", env_rf[6], 32'h1F8);

    // LDMIB with two wait states per beat.
    set_reg(8, 32'h40);
    fixed_rdata.push_back(32'h5A5A);
    launch(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 16'h0001, 2);
    wait_done(1'b0);
    check("ldmib_r0", env_rf[0], 32'h5A5A);
    check("ldmib_base_kept", env_rf[8], 32'h40);

    // LDMIA with base in list: loaded value wins.
    set_reg(2, 32'h1000);
    fixed_rdata.push_back(32'h2222); fixed_rdata.push_back(32'h7777);
    launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h0084, 0);
    wait_done(1'b0);
    check("ldmia_r2", env_rf[2], 32'h2222);
    check("ldmia_r7", env_rf[7], 32'h7777);

    // Empty list, start held with junk through DONE.
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0000, 0);
    wait_done(1'b1);

    // Reset during the second beat of a 4-register STM.
    launch(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 16'h00F0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_mem_req", 32'(mem_req), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_rf_we", 32'(rf_write_enable), 32'd0);
    beat_q.delete(); rfw_q.delete(); resp_q.delete(); done_q.delete();
    busy_cnt = 0; have_beat = 0; wait_left = 0;
    reset = 1'b0;
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 16'h00F0, 0);
    wait_done(1'b0);

    // Randomized transfers.
    for (int t = 0; t < 60; t++) begin
      bs = 4'($urandom);
      case ($urandom_range(0, 4))
        0: set_reg(int'(bs), 32'h0);
        1: set_reg(int'(bs), 32'hFFFF_FFF8);
        2: set_reg(int'(bs), $urandom);
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: list = 16'h0000;
        1: list = 16'hFFFF;
        2: list = 16'h0001 << $urandom_range(0, 15);
        default: list = 16'($urandom);
      endcase
      launch(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), bs, list, -1);
      wait_done(1'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    check("beat_q_drained", 32'(beat_q.size()), 32'd0);
    check("rfw_q_drained", 32'(rfw_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle sequencer for ARM LDM/STM block transfers.
- Sits between the decode/execute stage and the 16x32 register file plus the data-memory port.
- Walks the 16-bit register list lowest-to-highest, one register per accepted memory beat. Stores read from the register file; loads write into it.
- Optionally writes the updated base back through the register-file write port.

Parameters:
- ADDR_WIDTH, 32, memory address width. Base and writeback arithmetic are modulo 2^ADDR_WIDTH.
- NUM_REGS, 16, register-list width. Must equal the register-file depth.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch a transfer; sampled only in IDLE
- is_load  input  1  1 = LDM (memory to registers), 0 = STM (registers to memory)
- pre_index  input  1  P bit: 1 = before, 0 = after
- up  input  1  U bit: 1 = increment, 0 = decrement
- base_wb  input  1  W bit: write the updated base back
- base_sel  input  4  base register number
- base_addr  input  ADDR_WIDTH  current base register value
- reg_list  input  NUM_REGS  bit i set = transfer Ri
- busy  output  1  transfer in progress
- done  output  1  one-cycle completion pulse
- mem_req  output  1  memory beat request
- mem_we  output  1  1 = write beat
- mem_addr  output  ADDR_WIDTH  word address of the beat
- mem_wdata  output  32  store data
- mem_ready  input  1  beat accepted this cycle
- mem_rdata  input  32  load data, valid when mem_ready is high
- rf_read_sel  output  4  register-file read select
- rf_read_data  input  32  asynchronous read data from the register file
- rf_write_enable  output  1  register-file write strobe
- rf_write_sel  output  4  register-file write select
- rf_write_data  output  32  register-file write data

Behaviour:
- States: IDLE, XFER, WB, DONE.
- Reset values (any state, takes effect at the next edge): state = IDLE, all outputs 0, pending list cleared. Reset mid-transfer drops mem_req at that edge. No further rf writes occur.
- IDLE, start=1: capture all inputs; n = popcount(reg_list).
  - n=0: go to DONE. No memory or register-file activity.
  - n>0: go to XFER.
- Start address:
  - IA (P=0, U=1): base
  - IB (P=1, U=1): base+4
  - DA (P=0, U=0): base-4n+4
  - DB (P=1, U=0): base-4n
- Final base: base+4n if U=1, else base-4n.
- XFER:
  - mem_req=1, mem_we=~is_load, mem_addr = current address.
  - Current register = lowest set bit of the pending list.
  - Store: rf_read_sel = current register; mem_wdata = rf_read_data (combinational).
  - All request outputs are held stable while mem_ready=0.
  - Load: when mem_ready=1, in the same cycle drive rf_write_enable=1, rf_write_sel = current register, rf_write_data = mem_rdata.
  - On mem_ready=1: clear the current bit and add 4 to the address. If the pending list becomes empty, go to WB when base_wb=1 and not (is_load and reg_list[base_sel]); otherwise go to DONE.
  - The next beat begins the following cycle. At most one beat per cycle, so throughput is 1 register/cycle with zero wait states.
- WB (1 cycle): rf_write_enable=1, rf_write_sel=base_sel, rf_write_data = final base (zero-extended to 32), mem_req=0. Then go to DONE.
  - Load with the base in the list: the loaded value wins and WB is skipped.
  - Store with the base in the list: stores the original base value, since the store reads the register file before WB.
- DONE (1 cycle): done=1, busy=0. Then go to IDLE. start in DONE is ignored.
- busy = 1 in XFER and WB only. start is ignored while busy.
- rf_write_enable is 0 outside a load's ready cycle and WB. mem_req is 0 outside XFER.
- Address wrap-around is modulo arithmetic with no error flag.
- Latency with zero wait states: start edge to done high = n+1 cycles, or n+2 with WB. Empty list: done high in the cycle after start.

Test Plan:
- STMIA base=0x100, W=1, list {R1,R2,R5}, R1/R2/R5 = 0xA1/0xA2/0xA5, mem_ready always 1 -> write beats 0x100/0xA1, 0x104/0xA2, 0x108/0xA5; then rf write base_sel=0x10C; done 5 cycles after start.
- LDMDB base=0x200, W=1, list {R3,R4}, mem_rdata 0x33 then 0x44 -> read beats at 0x1F8, 0x1FC; R3=0x33, R4=0x44; base reg = 0x1F8.
- Wait states: mem_ready low 2 cycles per beat on LDMIB base=0x40, list {R0} -> mem_addr=0x44 held 3 cycles; single rf write on the ready cycle only.
- LDMIA base_sel=2, W=1, list {R2,R7} -> R2 gets loaded data, no WB write; done n+1 cycles after start.
- Empty list with start -> no mem_req, no rf write; done pulse exactly 1 cycle later, busy never high.
- Reset asserted during the 2nd beat of a 4-register STM -> next edge: mem_req=0, busy=0, state IDLE; a new start then runs cleanly from beat 1.
